// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_arbiter
// Description : Round-robin arbiter sharing one 8x8 multiplier among four
//               requesters, with a WAIT-state timeout that aborts hung ops.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_share_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [3:0]  req_ready,
  output logic [3:0]  rsp_valid,
  output logic [15:0] rsp_product,
  output logic        rsp_err,
  output logic        mul_start,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_product,
  input  logic        mul_done,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Count holds completed WAIT cycles, so the TIMEOUT-th WAIT cycle sees TIMEOUT-1.
  localparam logic [7:0] c_expire = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [1:0]  r_ptr;
  logic [1:0]  r_owner;
  logic [7:0]  r_count;
  logic [15:0] r_result;
  logic        r_err;
  logic [7:0]  r_op_a;
  logic [7:0]  r_op_b;

  logic        w_found;
  logic [1:0]  w_grant_idx;
  logic        w_accept;
  logic        w_expire;

  always_comb begin : rr_search
    logic [1:0] idx;
    w_found     = 1'b0;
    w_grant_idx = 2'd0;
    idx         = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = r_ptr + 2'(k);
      if (!w_found && req_valid[idx]) begin
        w_found     = 1'b1;
        w_grant_idx = idx;
      end
    end
  end

  // The asynchronous reset also masks the combinational grant path.
  assign w_accept = (r_state == S_IDLE) && w_found && !reset;
  assign w_expire = (r_count == c_expire);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= 2'd0;
      r_owner  <= 2'd0;
      r_count  <= 8'd0;
      r_result <= 16'd0;
      r_err    <= 1'b0;
      r_op_a   <= 8'd0;
      r_op_b   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_op_a  <= req_a[{w_grant_idx, 3'b000} +: 8];
            r_op_b  <= req_b[{w_grant_idx, 3'b000} +: 8];
            r_owner <= w_grant_idx;
            r_count <= 8'd0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            r_result <= mul_product;
            r_err    <= 1'b0;
            r_state  <= S_RESP;
          end else if (w_expire) begin
            r_result <= 16'd0;
            r_err    <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        S_RESP: begin
          r_ptr   <= r_owner + 2'd1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = w_accept ? (4'b0001 << w_grant_idx) : 4'b0000;
  assign rsp_valid   = (r_state == S_RESP) ? (4'b0001 << r_owner) : 4'b0000;
  assign rsp_product = r_result;
  assign rsp_err     = (r_state == S_RESP) && r_err;
  assign mul_start   = (r_state == S_ISSUE);
  assign mul_a       = r_op_a;
  assign mul_b       = r_op_b;
  assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
